burst_master: RTL
=================

# burst_master

Parametrised AXI-style burst master with independent read and write engines, generalising the fixed 8-bit single-outstanding master. Accepts one read and one write command at a time from a local command port, drives AR/R and AW/W/B channels with full valid/ready handshakes, streams read beats back, and reports per-burst completion status with length, ID and response checking. Sits between the testbench or controller command source and the slave interconnect.

## Interface
- ADDR_W, 8, address width
- DATA_W, 8, data beat width
- ID_W, 4, transaction ID width
- LEN_W, 4, burst length field width; beats = len+1, max 2^LEN_W
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rd_cmd_valid / rd_cmd_ready  in/out  1  read command handshake
- rd_cmd_addr, rd_cmd_len, rd_cmd_id  in  ADDR_W, LEN_W, ID_W  read command fields
- rd_beat_valid  out  1  one-cycle pulse per received beat
- rd_beat_data  out  DATA_W  beat data
- rd_done  out  1  one-cycle pulse at burst completion
- rd_status  out  4  {id_err, len_err, worst_resp[1:0]}
- wr_cmd_valid / wr_cmd_ready  in/out  1  write command handshake
- wr_cmd_addr, wr_cmd_len, wr_cmd_id  in  ADDR_W, LEN_W, ID_W  write command fields
- wr_cmd_data  in  DATA_W·2^LEN_W  beat i at [i·DATA_W +: DATA_W]
- wr_done  out  1  one-cycle pulse on B handshake
- wr_status  out  3  {id_err, resp[1:0]}
- ARVALID, ARREADY, ARADDR, ARLEN, ARID  out/in/out/out/out  1,1,ADDR_W,LEN_W,ID_W
- RVALID, RREADY, RDATA, RRESP, RLAST, RID  in/out/in/in/in/in  1,1,DATA_W,2,1,ID_W
- AWVALID, AWREADY, AWADDR, AWLEN, AWID  out/in/out/out/out  1,1,ADDR_W,LEN_W,ID_W
- WVALID, WREADY, WDATA, WLAST  out/in/out/out  1,1,DATA_W,1
- BVALID, BREADY, BRESP, BID  in/out/in/in  1,1,2,ID_W

## Operation
- Read FSM: R_IDLE → R_ADDR on rd_cmd_valid&&rd_cmd_ready (fields latched); R_ADDR → R_DATA on ARVALID&&ARREADY; R_DATA → R_IDLE on RVALID&&RREADY&&RLAST.
- Write FSM: W_IDLE → W_ADDR on wr command accept (fields and full data vector latched); W_ADDR → W_DATA on AW handshake; W_DATA → W_RESP on W handshake with WLAST; W_RESP → W_IDLE on BVALID&&BREADY.
- Engines fully independent; both may be active simultaneously.
- rd_cmd_ready = (R_IDLE); wr_cmd_ready = (W_IDLE). ARVALID = R_ADDR, RREADY = R_DATA, AWVALID = W_ADDR, WVALID = W_DATA, BREADY = W_RESP; all registered from state.
- AR/AW fields held stable from valid assertion through handshake.
- Beat counter (LEN_W bits) reset to 0 on command accept; increments per R or W handshake; saturates at all-ones.
- WDATA = latched beat[count]; WLAST = (count == len). Stable while WVALID && !WREADY.
- Read checks: len_err = RLAST on beat ≠ len, or beat count exceeded len before RLAST; id_err = any beat RID ≠ ARID; worst_resp = max RRESP over burst. Engine waits for RLAST regardless.
- Write checks: id_err = BID ≠ AWID; resp = BRESP.
- Status outputs hold until next done pulse.

## Timing
- Reset: all outputs 0 except rd_cmd_ready = wr_cmd_ready = 1; FSMs to IDLE; counters 0.
- Command accepted at cycle t → ARVALID/AWVALID high at t+1.
- AR handshake at t → RREADY high at t+1. AW handshake at t → WVALID with beat 0 at t+1.
- R handshake at k → rd_beat_valid/rd_beat_data at k+1; last beat → rd_done/rd_status at k+1.
- B handshake at k → wr_done/wr_status at k+1.
- Back-to-back W beats: one per cycle with WREADY held high.
- rst_n low mid-burst: outputs drop immediately, in-flight burst abandoned, no done pulse.
- New command not accepted on the done cycle; earliest accept one cycle after return to IDLE.

## Structure
- Package burst_master_pkg: read/write state enums, RESP_OKAY=0, RESP_EXOKAY=1, RESP_SLVERR=2, RESP_DECERR=3, status bit positions.
- Sub-module burst_wr_engine (write FSM, data latch, beat mux, B check); read engine inline in top.

## Test plan
- Read addr 0x40 len 3 id 5, ARREADY after 2 cycles, beats 0x11,0x22,0x33,0x44 RLAST on 4th → four rd_beat pulses in order, rd_done, rd_status 0x0.
- Write len 0 data 0xA5 id 2 → one beat WDATA 0xA5 WLAST=1; BRESP 0 BID 2 → wr_done, wr_status 0x0.
- Write len 15 data 0x00..0x0F, WREADY toggling → 16 beats in order, WDATA stable during stalls, WLAST only on 0x0F.
- Read len 3 with RLAST on beat 2, one RRESP=2 → rd_status len_err=1, worst_resp=2.
- BID 7 vs AWID 2 with BRESP 3 → wr_status 0x7; concurrent read completes unaffected.
- rst_n low mid write burst → all VALIDs 0 same cycle, cmd_ready 1 after release, no wr_done.

Source files
------------

// File: rtl/burst_master_pkg.sv
// Shared types and constants for the burst master read/write engines.
package burst_master_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  localparam int unsigned RESP_W  = 2;
  localparam int unsigned RD_ST_W = 4;
  localparam int unsigned WR_ST_W = 3;

  // Status bit positions; response occupies bits [1:0] in both words
  localparam int unsigned RD_ST_ID_ERR  = 3;
  localparam int unsigned RD_ST_LEN_ERR = 2;
  localparam int unsigned WR_ST_ID_ERR  = 2;

endpackage

// File: rtl/burst_wr_engine.sv
// Write engine: command latch, AW/W/B sequencing, beat mux and B check.
module burst_wr_engine
  import burst_master_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned LEN_W  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_cmd_valid,
  output logic                          wr_cmd_ready,
  input  logic [ADDR_W-1:0]             wr_cmd_addr,
  input  logic [LEN_W-1:0]              wr_cmd_len,
  input  logic [ID_W-1:0]               wr_cmd_id,
  input  logic [DATA_W*(1<<LEN_W)-1:0]  wr_cmd_data,
  output logic                          wr_done,
  output logic [WR_ST_W-1:0]            wr_status,
  output logic                          AWVALID,
  input  logic                          AWREADY,
  output logic [ADDR_W-1:0]             AWADDR,
  output logic [LEN_W-1:0]              AWLEN,
  output logic [ID_W-1:0]               AWID,
  output logic                          WVALID,
  input  logic                          WREADY,
  output logic [DATA_W-1:0]             WDATA,
  output logic                          WLAST,
  input  logic                          BVALID,
  output logic                          BREADY,
  input  logic [RESP_W-1:0]             BRESP,
  input  logic [ID_W-1:0]               BID
);

  localparam int unsigned BEATS = 1 << LEN_W;
  localparam int unsigned VEC_W = DATA_W * BEATS;
  localparam int unsigned IDX_W = $clog2(VEC_W);

  wr_state_e             wr_state;
  logic [VEC_W-1:0]      data_q;
  logic [LEN_W-1:0]      wr_cnt;
  logic [LEN_W-1:0]      wr_cnt_nxt;
  logic [IDX_W-1:0]      beat_base;
  logic [DATA_W-1:0]     next_beat;
  logic                  wr_accept;
  logic [WR_ST_W-1:0]    status_nxt;

  // Next beat selection from the latched data vector
  always_comb begin
    wr_cnt_nxt = wr_cnt + LEN_W'(1);
    beat_base  = IDX_W'(wr_cnt_nxt) * IDX_W'(DATA_W);
    next_beat  = data_q[beat_base +: DATA_W];
    wr_accept  = wr_cmd_valid && wr_cmd_ready;
  end

  // Completion status word assembled from the B channel
  always_comb begin
    status_nxt               = '0;
    status_nxt[WR_ST_ID_ERR] = (BID != AWID);
    status_nxt[1:0]          = BRESP;
  end

  // Write FSM with registered channel outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state     <= W_IDLE;
      wr_cmd_ready <= 1'b1;
      data_q       <= '0;
      wr_cnt       <= '0;
      wr_done      <= 1'b0;
      wr_status    <= '0;
      AWVALID      <= 1'b0;
      AWADDR       <= '0;
      AWLEN        <= '0;
      AWID         <= '0;
      WVALID       <= 1'b0;
      WDATA        <= '0;
      WLAST        <= 1'b0;
      BREADY       <= 1'b0;
    end else begin
      wr_done      <= 1'b0;
      wr_cmd_ready <= (wr_state == W_IDLE) && !wr_accept;
      case (wr_state)
        W_IDLE: begin
          if (wr_accept) begin
            AWADDR   <= wr_cmd_addr;
            AWLEN    <= wr_cmd_len;
            AWID     <= wr_cmd_id;
            data_q   <= wr_cmd_data;
            wr_cnt   <= '0;
            AWVALID  <= 1'b1;
            wr_state <= W_ADDR;
          end
        end
        W_ADDR: begin
          if (AWREADY) begin
            AWVALID  <= 1'b0;
            WVALID   <= 1'b1;
            WDATA    <= data_q[DATA_W-1:0];
            WLAST    <= (AWLEN == '0);
            wr_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (WREADY) begin
            wr_cnt <= (wr_cnt == '1) ? wr_cnt : wr_cnt_nxt;
            if (WLAST) begin
              WVALID   <= 1'b0;
              WLAST    <= 1'b0;
              BREADY   <= 1'b1;
              wr_state <= W_RESP;
            end else begin
              WDATA <= next_beat;
              WLAST <= (wr_cnt_nxt == AWLEN);
            end
          end
        end
        W_RESP: begin
          if (BVALID) begin
            BREADY    <= 1'b0;
            wr_done   <= 1'b1;
            wr_status <= status_nxt;
            wr_state  <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/burst_master.sv
// Burst master top: inline read engine plus instantiated write engine.
module burst_master
  import burst_master_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned LEN_W  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rd_cmd_valid,
  output logic                          rd_cmd_ready,
  input  logic [ADDR_W-1:0]             rd_cmd_addr,
  input  logic [LEN_W-1:0]              rd_cmd_len,
  input  logic [ID_W-1:0]               rd_cmd_id,
  output logic                          rd_beat_valid,
  output logic [DATA_W-1:0]             rd_beat_data,
  output logic                          rd_done,
  output logic [RD_ST_W-1:0]            rd_status,
  input  logic                          wr_cmd_valid,
  output logic                          wr_cmd_ready,
  input  logic [ADDR_W-1:0]             wr_cmd_addr,
  input  logic [LEN_W-1:0]              wr_cmd_len,
  input  logic [ID_W-1:0]               wr_cmd_id,
  input  logic [DATA_W*(1<<LEN_W)-1:0]  wr_cmd_data,
  output logic                          wr_done,
  output logic [WR_ST_W-1:0]            wr_status,
  output logic                          ARVALID,
  input  logic                          ARREADY,
  output logic [ADDR_W-1:0]             ARADDR,
  output logic [LEN_W-1:0]              ARLEN,
  output logic [ID_W-1:0]               ARID,
  input  logic                          RVALID,
  output logic                          RREADY,
  input  logic [DATA_W-1:0]             RDATA,
  input  logic [RESP_W-1:0]             RRESP,
  input  logic                          RLAST,
  input  logic [ID_W-1:0]               RID,
  output logic                          AWVALID,
  input  logic                          AWREADY,
  output logic [ADDR_W-1:0]             AWADDR,
  output logic [LEN_W-1:0]              AWLEN,
  output logic [ID_W-1:0]               AWID,
  output logic                          WVALID,
  input  logic                          WREADY,
  output logic [DATA_W-1:0]             WDATA,
  output logic                          WLAST,
  input  logic                          BVALID,
  output logic                          BREADY,
  input  logic [RESP_W-1:0]             BRESP,
  input  logic [ID_W-1:0]               BID
);

  rd_state_e            rd_state;
  logic [LEN_W-1:0]     rd_cnt;
  logic                 rd_id_err;
  logic                 rd_len_err;
  logic [RESP_W-1:0]    rd_worst;
  logic                 rd_accept;
  logic                 id_err_nxt;
  logic                 len_err_nxt;
  logic [RESP_W-1:0]    worst_nxt;
  logic [RD_ST_W-1:0]   status_nxt;

  // Sticky burst checks folded with the beat currently on the R channel
  always_comb begin
    rd_accept   = rd_cmd_valid && rd_cmd_ready;
    id_err_nxt  = rd_id_err || (RID != ARID);
    len_err_nxt = rd_len_err || (RLAST ? (rd_cnt != ARLEN) : (rd_cnt == ARLEN));
    worst_nxt   = (RRESP > rd_worst) ? RRESP : rd_worst;
    status_nxt                = '0;
    status_nxt[RD_ST_ID_ERR]  = id_err_nxt;
    status_nxt[RD_ST_LEN_ERR] = len_err_nxt;
    status_nxt[1:0]           = worst_nxt;
  end

  // Read FSM with registered channel outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state      <= R_IDLE;
      rd_cmd_ready  <= 1'b1;
      rd_cnt        <= '0;
      rd_id_err     <= 1'b0;
      rd_len_err    <= 1'b0;
      rd_worst      <= '0;
      rd_beat_valid <= 1'b0;
      rd_beat_data  <= '0;
      rd_done       <= 1'b0;
      rd_status     <= '0;
      ARVALID       <= 1'b0;
      ARADDR        <= '0;
      ARLEN         <= '0;
      ARID          <= '0;
      RREADY        <= 1'b0;
    end else begin
      rd_beat_valid <= 1'b0;
      rd_done       <= 1'b0;
      rd_cmd_ready  <= (rd_state == R_IDLE) && !rd_accept;
      case (rd_state)
        R_IDLE: begin
          if (rd_accept) begin
            ARADDR     <= rd_cmd_addr;
            ARLEN      <= rd_cmd_len;
            ARID       <= rd_cmd_id;
            ARVALID    <= 1'b1;
            rd_cnt     <= '0;
            rd_id_err  <= 1'b0;
            rd_len_err <= 1'b0;
            rd_worst   <= '0;
            rd_state   <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (ARREADY) begin
            ARVALID  <= 1'b0;
            RREADY   <= 1'b1;
            rd_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (RVALID) begin
            rd_beat_valid <= 1'b1;
            rd_beat_data  <= RDATA;
            rd_cnt        <= (rd_cnt == '1) ? rd_cnt : rd_cnt + LEN_W'(1);
            rd_id_err     <= id_err_nxt;
            rd_len_err    <= len_err_nxt;
            rd_worst      <= worst_nxt;
            if (RLAST) begin
              RREADY    <= 1'b0;
              rd_done   <= 1'b1;
              rd_status <= status_nxt;
              rd_state  <= R_IDLE;
            end
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  burst_wr_engine #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ID_W   (ID_W),
    .LEN_W  (LEN_W)
  ) u_wr (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_cmd_valid (wr_cmd_valid),
    .wr_cmd_ready (wr_cmd_ready),
    .wr_cmd_addr  (wr_cmd_addr),
    .wr_cmd_len   (wr_cmd_len),
    .wr_cmd_id    (wr_cmd_id),
    .wr_cmd_data  (wr_cmd_data),
    .wr_done      (wr_done),
    .wr_status    (wr_status),
    .AWVALID      (AWVALID),
    .AWREADY      (AWREADY),
    .AWADDR       (AWADDR),
    .AWLEN        (AWLEN),
    .AWID         (AWID),
    .WVALID       (WVALID),
    .WREADY       (WREADY),
    .WDATA        (WDATA),
    .WLAST        (WLAST),
    .BVALID       (BVALID),
    .BREADY       (BREADY),
    .BRESP        (BRESP),
    .BID          (BID)
  );

endmodule
